block_counter: RTL and testbench
================================

BLOCK_COUNTER -- requirements
Module: block_counter

Interface
REQ-001 SHALL have parameter CTR_BITS, default 32, meaning counter width (legal values 32 or 64).
REQ-002 SHALL have parameter INITIAL_VALUE, default 0, meaning the value loaded at reset and on clear.
REQ-003 SHALL have parameter WRAP_EN, default 0, meaning 1 = wrap past max, 0 = stop at max.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous return to IDLE with counter = INITIAL_VALUE.
REQ-007 SHALL have port load_i, input, 1 bit: load load_value_i and start issuing.
REQ-008 SHALL have port load_value_i, input, CTR_BITS bits: start value.
REQ-009 SHALL have port ctr_valid_o, output, 1 bit: ctr_o holds an issuable block number.
REQ-010 SHALL have port ctr_ready_i, input, 1 bit: consumer accepts ctr_o.
REQ-011 SHALL have port ctr_o, output, CTR_BITS bits: current block number.
REQ-012 SHALL have port exhausted_o, output, 1 bit: counter space used up (WRAP_EN=0 only).
REQ-013 SHALL have port wrapped_o, output, 1 bit: sticky flag, the counter has wrapped (WRAP_EN=1 only).

Function
REQ-014 SHALL implement states IDLE, RUN and EXHAUSTED.
REQ-015 SHALL assert ctr_valid_o only in RUN.
REQ-016 SHALL assert exhausted_o only in EXHAUSTED.
REQ-017 SHALL count a transfer when ctr_valid_o and ctr_ready_i are both high on a rising edge.
REQ-018 IDLE: on load_i=1, SHALL set ctr_o=load_value_i and enter RUN; ctr_valid_o is high on the next cycle (1-cycle latency).
REQ-019 RUN: on a transfer, SHALL set ctr_o = ctr_o+1 (modulo 2^CTR_BITS) with no bubble; ctr_valid_o stays high.
REQ-020 RUN, WRAP_EN=0, transfer with ctr_o = all-ones: SHALL leave ctr_o unchanged and enter EXHAUSTED.
REQ-021 RUN, WRAP_EN=1, transfer with ctr_o = all-ones: SHALL set ctr_o=0, remain in RUN and set wrapped_o.
REQ-022 SHALL hold ctr_o and ctr_valid_o stable while ctr_valid_o=1 and ctr_ready_i=0.
REQ-023 load_i in RUN or EXHAUSTED: SHALL reload ctr_o=load_value_i, enter RUN and clear wrapped_o; a coincident ctr_ready_i is not a transfer.
REQ-024 EXHAUSTED: SHALL ignore ctr_ready_i and leave only on load_i, clear_i or reset.
REQ-025 clear_i SHALL take priority over load_i: go to IDLE, set ctr_o=INITIAL_VALUE and clear wrapped_o.
REQ-026 Priority SHALL be rst_ni low > clear_i > load_i > transfer.
REQ-027 WRAP_EN=0: wrapped_o SHALL be constant 0; WRAP_EN=1: exhausted_o SHALL be constant 0.
REQ-028 load_value_i SHALL be sampled only in the cycle load_i is high.

Reset
REQ-029 rst_ni low at a rising edge SHALL force IDLE, ctr_o=INITIAL_VALUE, ctr_valid_o=0, exhausted_o=0 and wrapped_o=0, including mid-stream.
REQ-030 SHALL use no asynchronous reset paths.

Structure
REQ-031 State encoding (IDLE/RUN/EXHAUSTED) SHALL be a typedef in the shared chacha package, together with constants for the RFC 8439 (32) and original (64) counter widths.
REQ-032 The counter register with its increment and terminal-count compare SHALL be a sub-module, block_counter_core; FSM and handshake logic SHALL stay in block_counter.
REQ-033 SHALL use no combinational path from ctr_ready_i to ctr_valid_o.

Verification
REQ-034 Reset then load_i with 5 -> ctr_valid_o=1 next cycle, ctr_o=5; ctr_ready_i held high 3 cycles -> ctr_o reads 5, 6, 7, 8.
REQ-035 Backpressure: ctr_ready_i=0 for 4 cycles in RUN -> ctr_o constant and ctr_valid_o=1 throughout.
REQ-036 WRAP_EN=0, CTR_BITS=32, load 0xFFFFFFFE, 2 transfers -> EXHAUSTED, ctr_valid_o=0, exhausted_o=1, ctr_o=0xFFFFFFFF; further ctr_ready_i has no effect.
REQ-037 WRAP_EN=1, CTR_BITS=64, load all-ones, 1 transfer -> ctr_o=0, wrapped_o=1, still RUN; load_i -> wrapped_o=0.
REQ-038 clear_i and load_i asserted together in RUN -> IDLE, ctr_o=INITIAL_VALUE; load_i with a transfer in the same cycle -> ctr_o=load_value_i, not incremented.
REQ-039 rst_ni low mid-stream at ctr_o=100 -> next cycle IDLE, ctr_o=INITIAL_VALUE, all flags 0.

Source files
------------

// File: rtl/block_counter_pkg.sv
// Shared definitions for the ChaCha block counter: FSM state encoding and the
// standard counter widths.
package block_counter_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRun       = 2'd1,
    StExhausted = 2'd2
  } ctr_state_e;

  // RFC 8439 uses a 32-bit block counter; the original ChaCha uses 64 bits.
  localparam int unsigned CtrBitsRfc8439 = 32;
  localparam int unsigned CtrBitsOrig    = 64;

endpackage

// File: rtl/block_counter_core.sv
// Block-number register with increment and terminal-count detect.
// Priority: reset > clear > load > increment.
module block_counter_core #(
  parameter int unsigned           CTR_BITS      = 32,
  parameter logic [CTR_BITS-1:0]   INITIAL_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_value,
  input  logic                incr,
  output logic [CTR_BITS-1:0] ctr,
  output logic                at_max
);

  logic [CTR_BITS-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (clear) begin
      ctr_d = INITIAL_VALUE;
    end else if (load) begin
      ctr_d = load_value;
    end else if (incr) begin
      // Natural modulo-2^CTR_BITS roll-over.
      ctr_d = ctr_q + {{(CTR_BITS-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_q <= INITIAL_VALUE;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr    = ctr_q;
  assign at_max = &ctr_q;

endmodule

// File: rtl/block_counter.sv
// ChaCha block-number issuer: IDLE/RUN/EXHAUSTED FSM with a valid/ready
// handshake around the block_counter_core register.
module block_counter
  import block_counter_pkg::*;
#(
  parameter int unsigned         CTR_BITS      = CtrBitsRfc8439,
  parameter logic [CTR_BITS-1:0] INITIAL_VALUE = '0,
  parameter bit                  WRAP_EN       = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [CTR_BITS-1:0] load_value_i,
  output logic                ctr_valid_o,
  input  logic                ctr_ready_i,
  output logic [CTR_BITS-1:0] ctr_o,
  output logic                exhausted_o,
  output logic                wrapped_o
);

  ctr_state_e state_q, state_d;
  logic       wrapped_q, wrapped_d;
  logic       transfer;
  logic       incr;
  logic       at_max;

  // Outputs come straight from registered state, so ready never reaches valid.
  assign transfer = (state_q == StRun) && ctr_ready_i;

  always_comb begin
    state_d   = state_q;
    wrapped_d = wrapped_q;
    incr      = 1'b0;
    if (clear_i) begin
      state_d   = StIdle;
      wrapped_d = 1'b0;
    end else if (load_i) begin
      state_d   = StRun;
      wrapped_d = 1'b0;
    end else if (transfer) begin
      if (!at_max) begin
        incr = 1'b1;
      end else if (WRAP_EN) begin
        incr      = 1'b1;
        wrapped_d = 1'b1;
      end else begin
        state_d = StExhausted;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrapped_q <= wrapped_d;
    end
  end

  block_counter_core #(
    .CTR_BITS      (CTR_BITS),
    .INITIAL_VALUE (INITIAL_VALUE)
  ) u_core (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .clear      (clear_i),
    .load       (load_i),
    .load_value (load_value_i),
    .incr       (incr),
    .ctr        (ctr_o),
    .at_max     (at_max)
  );

  assign ctr_valid_o = (state_q == StRun);
  assign exhausted_o = !WRAP_EN && (state_q == StExhausted);
  assign wrapped_o   = WRAP_EN && wrapped_q;

endmodule

// File: tb/tb_block_counter.sv
// Two instances (32-bit saturating, 64-bit wrapping) driven in lockstep and
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_block_counter;

  localparam logic [31:0] InitA = 32'h0000_0010;
  localparam logic [63:0] InitB = 64'd0;

  typedef struct {
    logic [63:0] ctr;
    bit          valid;
    bit          exh;
    bit          wrap;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n, clear, load, ready;
  logic [31:0] lv_a;
  logic [63:0] lv_b;

  logic        a_valid, a_exh, a_wrap;
  logic [31:0] a_ctr;
  logic        b_valid, b_exh, b_wrap;
  logic [63:0] b_ctr;

  int checks = 0;
  int errors = 0;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  block_counter #(
    .CTR_BITS      (32),
    .INITIAL_VALUE (InitA),
    .WRAP_EN       (1'b0)
  ) dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .load_i       (load),
    .load_value_i (lv_a),
    .ctr_valid_o  (a_valid),
    .ctr_ready_i  (ready),
    .ctr_o        (a_ctr),
    .exhausted_o  (a_exh),
    .wrapped_o    (a_wrap)
  );

  block_counter #(
    .CTR_BITS      (64),
    .INITIAL_VALUE (InitB),
    .WRAP_EN       (1'b1)
  ) dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .load_i       (load),
    .load_value_i (lv_b),
    .ctr_valid_o  (b_valid),
    .ctr_ready_i  (ready),
    .ctr_o        (b_ctr),
    .exhausted_o  (b_exh),
    .wrapped_o    (b_wrap)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, expressed directly from the rules.
  function automatic mdl_t step(input mdl_t m, input int bits, input bit wrap_en,
                                input logic [63:0] init, input logic [63:0] lv);
    mdl_t        n   = m;
    logic [63:0] top = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (!rst_n || clear) begin
      n.ctr = init; n.valid = 0; n.exh = 0; n.wrap = 0;
    end else if (load) begin
      n.ctr = lv & top; n.valid = 1; n.exh = 0; n.wrap = 0;
    end else if (m.valid && ready) begin
      if (m.ctr != top) n.ctr = m.ctr + 1;
      else if (wrap_en) begin n.ctr = 0; n.wrap = 1; end
      else begin n.valid = 0; n.exh = 1; end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = step(ma, 32, 1'b0, {32'd0, InitA}, {32'd0, lv_a});
    mb = step(mb, 64, 1'b1, InitB, lv_b);
    #1;
    chk("a_ctr",   {32'd0, a_ctr}, ma.ctr);
    chk("a_valid", a_valid,        ma.valid);
    chk("a_exh",   a_exh,          ma.exh);
    chk("a_wrap",  a_wrap,         ma.wrap);
    chk("b_ctr",   b_ctr,          mb.ctr);
    chk("b_valid", b_valid,        mb.valid);
    chk("b_exh",   b_exh,          mb.exh);
    chk("b_wrap",  b_wrap,         mb.wrap);
  end

  task automatic cyc(input logic r, input logic c, input logic l, input logic rd,
                     input logic [31:0] va, input logic [63:0] vb);
    @(negedge clk);
    rst_n = r; clear = c; load = l; ready = rd; lv_a = va; lv_b = vb;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; clear = 0; load = 0; ready = 0; lv_a = 0; lv_b = 0;
    ma = '{ctr: 0, valid: 0, exh: 0, wrap: 0};
    mb = ma;

    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("rst_a_ctr", {32'd0, a_ctr}, 64'h10);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_ctr", b_ctr, 0);

    // Load 5 then three transfers: 5, 6, 7, 8.
    cyc(1, 0, 1, 0, 32'd5, 64'd5);
    chk("load5_valid", a_valid, 1);
    chk("load5_ctr", {32'd0, a_ctr}, 64'd5);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 32'hDEAD_BEEF, 64'd0);
      chk("xfer_ctr", {32'd0, a_ctr}, 64'd6 + 64'(i));
    end

    // Backpressure holds value and valid.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("bp_ctr", {32'd0, a_ctr}, 64'd8);
      chk("bp_valid", a_valid, 1);
    end

    // Saturation (a) and wrap (b).
    cyc(1, 0, 1, 0, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1, 0, 0, 1, 0, 0);
    chk("wrap_b_ctr", b_ctr, 64'd0);
    chk("wrap_b_flag", b_wrap, 1);
    chk("wrap_b_valid", b_valid, 1);
    cyc(1, 0, 0, 1, 0, 0);
    chk("exh_a_flag", a_exh, 1);
    chk("exh_a_valid", a_valid, 0);
    chk("exh_a_ctr", {32'd0, a_ctr}, 64'hFFFF_FFFF);
    cyc(1, 0, 0, 1, 0, 0);
    chk("exh_a_hold", {32'd0, a_ctr}, 64'hFFFF_FFFF);
    chk("exh_a_stay", a_exh, 1);

    // Load with coincident ready: no increment, wrapped cleared.
    cyc(1, 0, 1, 1, 32'd100, 64'd100);
    chk("ld_xfer_ctr", {32'd0, a_ctr}, 64'd100);
    chk("ld_a_exh", a_exh, 0);
    chk("ld_b_wrap", b_wrap, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 1, 1, 32'd7, 64'd7);
    chk("clr_a_ctr", {32'd0, a_ctr}, 64'h10);
    chk("clr_a_valid", a_valid, 0);

    // Reset mid-stream at 100.
    cyc(1, 0, 1, 0, 32'd99, 64'd99);
    cyc(1, 0, 0, 1, 0, 0);
    chk("pre_rst_ctr", {32'd0, a_ctr}, 64'd100);
    cyc(0, 0, 0, 1, 0, 0);
    chk("mid_rst_ctr", {32'd0, a_ctr}, 64'h10);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_b_ctr", b_ctr, 0);

    // Randomized traffic, biased toward values near the top of the range.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] va;
      logic [63:0] vb;
      va = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 6);
      vb = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom}
                                       : 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 6));
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), va, vb);
    end

    cyc(1, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
